mii_tx_frame_arbiter: RTL
=========================

// Module: mii_tx_frame_arbiter
// PURPOSE
// Frame-granular round-robin arbiter that shares the byte-wide TX AXI-stream input of the MII MAC
// (eth_mac_mii_fifo tx_axis_*) between NUM_SRC requesters (uDMA TX channel, pause/control frame gen).
// A grant is held from first beat to tlast, so frames are never interleaved.
// A stalled or oversize frame is terminated with tuser=1, and the MAC TX frame FIFO then drops it.
// PARAMETERS
// NUM_SRC      2     number of requesters, 2..4
// MAX_LEN      1518  max beats per frame; beat MAX_LEN without tlast is forced to end the frame
// TIMEOUT_CYC  1024  consecutive granted-source tvalid=0 cycles mid-frame before abort, >=2
// PORTS
// clk             in   1          system clock (MAC logic_clk domain)
// rst_n           in   1          asynchronous active-low reset
// src_en          in   NUM_SRC    per-source arbitration enable (quasi-static)
// s_axis_tdata    in   NUM_SRC*8  source bytes, source i at [8i+7:8i]
// s_axis_tvalid   in   NUM_SRC    source valid
// s_axis_tready   out  NUM_SRC    source ready
// s_axis_tlast    in   NUM_SRC    source end of frame
// s_axis_tuser    in   NUM_SRC    source bad-frame marker (forwarded)
// m_axis_tdata    out  8          to MAC tx_axis_tdata
// m_axis_tvalid   out  1          to MAC tx_axis_tvalid
// m_axis_tready   in   1          from MAC tx_axis_tready
// m_axis_tlast    out  1          to MAC tx_axis_tlast
// m_axis_tuser    out  1          to MAC tx_axis_tuser
// grant           out  NUM_SRC    one-hot current owner, 0 when IDLE
// busy            out  1          state != IDLE
// abort_pulse     out  1          1-cycle pulse: frame terminated by timeout
// oversize_pulse  out  1          1-cycle pulse: frame truncated at MAX_LEN
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, grant=0, counters=0; all outputs 0.
//   Reset mid-frame discards the frame in flight; nothing is re-sent.
// - States IDLE, STREAM, ABORT, DRAIN. State, grant, rr_ptr and counters are registered.
//   m_axis_* and s_axis_tready are combinational from state and grant, with no added pipeline.
// - IDLE: requesters = s_axis_tvalid & src_en. Pick the first requester searching from rr_ptr+1
//   upward with wrap. Register grant, beat_cnt=0, to_cnt=0 -> STREAM.
//   Arbitration latency is 1 cycle: the first beat can transfer the cycle after the request is seen.
//   No m_axis_tvalid in IDLE. There is at least 1 IDLE cycle between frames.
// - STREAM: m_axis_* = granted source's signals. s_axis_tready[g] = m_axis_tready; other readys 0.
//   - Beat accepted (m_tvalid&m_tready): beat_cnt++, to_cnt=0.
//   - tlast accepted: rr_ptr=g, grant=0 -> IDLE.
//   - beat_cnt==MAX_LEN-1 and an accepted beat has tlast=0: force m_tlast=1 and m_tuser=1 on
//     that beat, pulse oversize_pulse -> DRAIN.
//   - Granted s_tvalid=0: to_cnt++. A cycle with tvalid=1 and tready=0 is not a stall and
//     clears to_cnt. On to_cnt==TIMEOUT_CYC-1 with tvalid still 0 -> ABORT.
//   - src_en deasserted mid-frame has no effect until the frame ends.
// - ABORT: drive m_tvalid=1, m_tdata=8'h00, m_tlast=1, m_tuser=1, all s_tready=0.
//   On m_tready: pulse abort_pulse -> DRAIN. If beat_cnt==0 (granted but no byte sent), skip the
//   filler beat: pulse and go directly to DRAIN.
// - DRAIN: m_tvalid=0. s_axis_tready[g]=1, discarding granted-source beats until one with tlast=1
//   is accepted; then rr_ptr=g -> IDLE. No timeout in DRAIN.
// - Width: beat_cnt is $clog2(MAX_LEN+1) bits and never wraps. to_cnt is $clog2(TIMEOUT_CYC) bits
//   and saturates.
// - Simultaneous: tlast on the MAX_LEN-th beat is a normal end, with no oversize pulse.
//   tvalid returning on the cycle to_cnt would expire continues STREAM.
// - AXI rules: m_axis_* stay stable while m_tvalid&!m_tready.
//   Source tuser is passed through unmodified in STREAM.
// TESTING
// T1 src0 and src1 both request 3-byte frames simultaneously after reset -> src1 sent first
//    (rr_ptr=0), then src0. No interleave; exactly 1 IDLE cycle between frames.
// T2 m_axis_tready toggles 1/0 during a 64-byte src0 frame -> byte order intact;
//    to_cnt stays 0; no abort.
// T3 src1 stops after 10 bytes (TIMEOUT_CYC=16) -> abort beat 00 with tlast=1, tuser=1 after
//    16 idle cycles; abort_pulse once; src1 drained to its tlast; then src0 served.
// T4 MAX_LEN=8, src0 sends 12 bytes -> byte 8 out with tlast=1, tuser=1; oversize_pulse once;
//    bytes 9-12 consumed and discarded.
// T5 src_en=2'b01 with both sources valid -> only src0 is granted;
//    src1 s_tready stays 0 throughout.
// T6 rst_n asserted mid-frame (byte 5 of 20) -> all outputs 0 immediately; after release
//    rr_ptr=0 and fresh arbitration.

Source files
------------

// File: rtl/mii_tx_frame_arbiter.sv
// mii_tx_frame_arbiter
//   Frame-granular round-robin arbiter in front of the byte-wide TX AXI-stream
//   input of the MII MAC. A grant is held from the first beat to tlast, so
//   frames from different sources never interleave. A frame that stalls for
//   too long gets one filler beat with tlast=1/tuser=1. A frame that runs past
//   MAX_LEN is cut short with tlast=1/tuser=1. In both cases the MAC frame FIFO
//   drops the frame, and the rest of the source frame is then consumed
//   silently.
//
// Handshake: a beat moves on a port in any cycle where tvalid && tready.
//   Once tvalid is raised, tvalid and the payload stay stable until that
//   cycle. m_axis_* and s_axis_tready are combinational from state and grant.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   src_en            per-source arbitration enable
//   s_axis_*          NUM_SRC source streams, source i data at [8i+7:8i]
//   m_axis_*          merged stream to the MAC
//   grant             one-hot current owner, 0 when idle
//   busy              arbiter is not idle
//   abort_pulse       1-cycle pulse, frame terminated by stall timeout
//   oversize_pulse    1-cycle pulse, frame truncated at MAX_LEN
//   dbg_state_o       current FSM state (debug observation only)
module mii_tx_frame_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int MAX_LEN     = 1518,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_en,
  input  logic [NUM_SRC*8-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]   s_axis_tvalid,
  output logic [NUM_SRC-1:0]   s_axis_tready,
  input  logic [NUM_SRC-1:0]   s_axis_tlast,
  input  logic [NUM_SRC-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 busy,
  output logic                 abort_pulse,
  output logic                 oversize_pulse,
  output logic [1:0]           dbg_state_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_ABORT, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;

  logic [NUM_SRC-1:0] req;
  logic               found;
  logic [IW-1:0]      pick_idx;
  logic [7:0]         g_data;
  logic               g_valid, g_last, g_user;
  logic               at_max;

  assign req = s_axis_tvalid & src_en;

  // Round-robin search starting one past the last served source.
  always_comb begin
    int idx;
    found    = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        found    = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

  // Signals of the granted source.
  always_comb begin
    g_data  = s_axis_tdata[{gidx_q, 3'b000} +: 8];
    g_valid = s_axis_tvalid[gidx_q];
    g_last  = s_axis_tlast[gidx_q];
    g_user  = s_axis_tuser[gidx_q];
  end

  // The next accepted beat would be beat number MAX_LEN.
  assign at_max = (beat_cnt_q == BW'(MAX_LEN - 1));

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_ptr_d       = rr_ptr_q;
    beat_cnt_d     = beat_cnt_q;
    to_cnt_d       = to_cnt_q;
    m_axis_tdata   = 8'h00;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s_axis_tready  = '0;
    abort_pulse    = 1'b0;
    oversize_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d    = NUM_SRC'(1) << pick_idx;
          gidx_d     = pick_idx;
          beat_cnt_d = '0;
          to_cnt_d   = '0;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        m_axis_tdata          = g_data;
        m_axis_tvalid         = g_valid;
        m_axis_tlast          = g_last;
        m_axis_tuser          = g_user;
        s_axis_tready[gidx_q] = m_axis_tready;
        // The truncation marker depends only on the count and the source
        // payload, so it stays stable while the MAC back-pressures.
        if (at_max && !g_last) begin
          m_axis_tlast = 1'b1;
          m_axis_tuser = 1'b1;
        end
        if (g_valid && m_axis_tready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          to_cnt_d   = '0;
          if (g_last) begin
            rr_ptr_d = gidx_q;
            grant_d  = '0;
            state_d  = ST_IDLE;
          end else if (at_max) begin
            oversize_pulse = 1'b1;
            state_d        = ST_DRAIN;
          end
        end else if (!g_valid) begin
          // Only a missing source beat counts as a stall. MAC back-pressure
          // does not.
          if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = ST_ABORT;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else begin
          to_cnt_d = '0;
        end
      end
      ST_ABORT: begin
        if (beat_cnt_q == '0) begin
          // The MAC has seen nothing of this frame, so no filler is needed.
          abort_pulse = 1'b1;
          state_d     = ST_DRAIN;
        end else begin
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = 1'b1;
          m_axis_tuser  = 1'b1;
          if (m_axis_tready) begin
            abort_pulse = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        s_axis_tready[gidx_q] = 1'b1;
        if (g_valid && g_last) begin
          rr_ptr_d = gidx_q;
          grant_d  = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
